// File: rtl/spi_master_shift_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM state encodings and default sizing.
package spi_master_shift_pkg;

  localparam int W_SPI_ST    = 3;
  localparam int W_SPI_DATA  = 32;
  localparam int SPI_CLK_DIV = 4;

  typedef enum logic [W_SPI_ST-1:0] {
    SPI_IDLE  = 3'd0,
    SPI_LEAD  = 3'd1,
    SPI_SHIFT = 3'd2,
    SPI_TRAIL = 3'd3,
    SPI_DONE  = 3'd4
  } spi_state_e;

  // Width of a counter that must hold the values 0..n-1 (never narrower than 1 bit).
  function automatic int spi_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_shift_clk_div.sv
// Half-period tick generator for the SPI master: one tick every CLK_DIV enabled cycles.
module spi_clk_div
  import spi_master_shift_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int              CW = spi_cnt_w(CLK_DIV);
  localparam logic [CW-1:0]   TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (i_clr) begin
      r_div_cnt <= '0;
    end else if (i_en) begin
      r_div_cnt <= (r_div_cnt == TC) ? '0 : r_div_cnt + 1'b1;
    end
  end

  // Terminal count doubles as the half-period tick; suppressed while held clear.
  assign o_tick = i_en & ~i_clr & (r_div_cnt == TC);

endmodule

// File: rtl/spi_master_shift.sv
// SPI mode-0 master: accepts a parallel word, shifts it out MSB-first on mosi while
// shifting miso in, then presents the received word with a one-cycle rx_valid pulse.
module spi_master_shift
  import spi_master_shift_pkg::*;
#(
  parameter int DATA_W  = W_SPI_DATA,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy,
  output logic              o_spi_sclk,
  output logic              o_spi_mosi,
  input  logic              i_spi_miso,
  output logic              o_spi_cs_n
);

  localparam int            BW       = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [BW-1:0] ALL_BITS = BW'(DATA_W);

  spi_state_e        r_state;
  logic [DATA_W-1:0] r_tx_sr;
  logic [DATA_W-1:0] r_rx_sr;
  logic [DATA_W-1:0] r_rx_data;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_rx_valid;
  logic              r_tx_ready;
  logic              r_busy;
  logic              r_sclk;
  logic              r_cs_n;

  logic w_tick;
  logic w_accept;
  logic w_div_en;
  logic w_div_clr;

  assign w_accept  = i_tx_valid & r_tx_ready;
  assign w_div_en  = (r_state != SPI_IDLE);
  assign w_div_clr = (r_state == SPI_IDLE);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_div_en),
    .i_clr  (w_div_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SPI_IDLE;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        SPI_IDLE: begin
          if (w_accept) begin
            r_tx_sr    <= i_tx_data;
            r_rx_sr    <= '0;
            r_bit_cnt  <= '0;
            r_cs_n     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= SPI_LEAD;
          end
        end
        SPI_LEAD: begin
          if (w_tick) r_state <= SPI_SHIFT;
        end
        SPI_SHIFT: begin
          if (w_tick) begin
            if (!r_sclk) begin
              r_sclk  <= 1'b1;
              r_rx_sr <= {r_rx_sr[DATA_W-2:0], i_spi_miso};
            end else begin
              r_sclk <= 1'b0;
              // The falling edge after the last bit ends the shift without advancing mosi.
              if (r_bit_cnt == LAST_BIT) begin
                r_bit_cnt <= ALL_BITS;
                r_state   <= SPI_TRAIL;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_tx_sr   <= {r_tx_sr[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
        SPI_TRAIL: begin
          if (w_tick) begin
            r_cs_n     <= 1'b1;
            r_rx_valid <= 1'b1;
            r_rx_data  <= r_rx_sr;
            r_tx_sr    <= '0;
            r_state    <= SPI_DONE;
          end
        end
        SPI_DONE: begin
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= SPI_IDLE;
        end
        default: begin
          r_sclk     <= 1'b0;
          r_cs_n     <= 1'b1;
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= SPI_IDLE;
        end
      endcase
    end
  end

  // mosi is the shift register MSB, so it changes only on clk edges that load or shift.
  assign o_spi_mosi = r_tx_sr[DATA_W-1];
  assign o_spi_sclk = r_sclk;
  assign o_spi_cs_n = r_cs_n;
  assign o_tx_ready = r_tx_ready;
  assign o_busy     = r_busy;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;

endmodule

// File: tb/tb_spi_master_shift.sv
// Directed bench for spi_master_shift: table of single transfers plus hand-written corner sequences.
module tb_spi_master_shift;

  localparam int DW      = 8;
  localparam int CD      = 2;
  localparam int EXP_LAT = 1 + 2*CD + 2*CD*DW;   // 37
  localparam int EXP_CSN = 2*CD + 2*CD*DW;       // 36 cycles with cs_n low

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: DATA_W=8, CLK_DIV=2
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, rx_valid, busy, sclk, mosi, cs_n;
  logic [DW-1:0] rx_data;
  logic          miso;
  logic [1:0]    mode = 2'd0;  // 0 loopback, 1 tied high, 2 tied low

  always_comb begin
    miso = 1'b0;
    case (mode)
      2'd0:    miso = mosi;
      2'd1:    miso = 1'b1;
      default: miso = 1'b0;
    endcase
  end

  spi_master_shift #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_busy(busy),
    .o_spi_sclk(sclk), .o_spi_mosi(mosi), .i_spi_miso(miso), .o_spi_cs_n(cs_n)
  );

  // DUT B: DATA_W=32, CLK_DIV=4, loopback
  logic [31:0] tx_data32 = '0;
  logic        tx_valid32 = 1'b0;
  logic        tx_ready32, rx_valid32, busy32, sclk32, mosi32, cs_n32;
  logic [31:0] rx_data32;

  spi_master_shift #(.DATA_W(32), .CLK_DIV(4)) dut32 (
    .clk(clk), .rst(rst),
    .i_tx_data(tx_data32), .i_tx_valid(tx_valid32), .o_tx_ready(tx_ready32),
    .o_rx_data(rx_data32), .o_rx_valid(rx_valid32), .o_busy(busy32),
    .o_spi_sclk(sclk32), .o_spi_mosi(mosi32), .i_spi_miso(mosi32), .o_spi_cs_n(cs_n32)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cumulative monitor on DUT A, sampled mid-cycle.
  int          acc_cnt = 0, acc_cyc = 0, rv_cnt = 0, rv_cyc = 0;
  int          rises_m = 0, csn_low_m = 0, mosi_hi_m = 0;
  int          csn_rise_cyc = 0, csn_fall_cyc = 0;
  logic [31:0] mosi_sh_m = '0;
  logic        prev_sclk = 1'b0, prev_csn = 1'b1;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin acc_cnt <= acc_cnt + 1; acc_cyc <= cyc; end
    if (rx_valid) begin rv_cnt <= rv_cnt + 1; rv_cyc <= cyc; end
    if (sclk && !prev_sclk) begin
      rises_m   <= rises_m + 1;
      mosi_sh_m <= {mosi_sh_m[30:0], mosi};
    end
    if (!cs_n) csn_low_m <= csn_low_m + 1;
    if (!cs_n && mosi) mosi_hi_m <= mosi_hi_m + 1;
    if (cs_n && !prev_csn) csn_rise_cyc <= cyc;
    if (!cs_n && prev_csn) csn_fall_cyc <= cyc;
    prev_sclk <= sclk;
    prev_csn  <= cs_n;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_rv(input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(posedge clk); #1;
      if (rx_valid) begin ok = 1'b1; break; end
    end
    check("rx_valid_seen", 32'(ok), 32'd1);
  endtask

  task automatic send(input logic [DW-1:0] tx, output logic [DW-1:0] rx, output int lat,
                      output int rises, output int csn, output logic [DW-1:0] mw, output int mh);
    int r0, c0, h0;
    bit ok;
    @(posedge clk); #1;
    r0 = rises_m; c0 = csn_low_m; h0 = mosi_hi_m;
    tx_data = tx; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_rv(200, ok);
    rx = rx_data;
    @(negedge clk); #1;
    lat = rv_cyc - acc_cyc;
    rises = rises_m - r0;
    csn = csn_low_m - c0;
    mh = mosi_hi_m - h0;
    mw = mosi_sh_m[DW-1:0];
  endtask

  typedef struct {
    logic [DW-1:0] tx;
    logic [1:0]    miso_mode;
    logic [DW-1:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [DW-1:0] rx, mw;
    int lat, rises, csn, mh, rv0, acc0, prev_s, nr, t32;
    bit ok;

    vecs[0] = '{8'hA5, 2'd0, 8'hA5};
    vecs[1] = '{8'h00, 2'd1, 8'hFF};
    vecs[2] = '{8'h81, 2'd0, 8'h81};
    vecs[3] = '{8'h81, 2'd1, 8'hFF};
    vecs[4] = '{8'h3C, 2'd2, 8'h00};
    vecs[5] = '{8'hFF, 2'd0, 8'hFF};

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data",  32'(rx_data),  32'd0);
    check("rst_sclk",     32'(sclk),     32'd0);
    check("rst_mosi",     32'(mosi),     32'd0);
    check("rst_cs_n",     32'(cs_n),     32'd1);
    check("rst_ready32",  32'(tx_ready32), 32'd1);
    rst = 1'b0;

    // Table-driven single transfers
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].miso_mode;
      send(vecs[i].tx, rx, lat, rises, csn, mw, mh);
      check($sformatf("v%0d_rx_data", i),  32'(rx),    32'(vecs[i].exp_rx));
      check($sformatf("v%0d_latency", i),  32'(lat),   32'(EXP_LAT));
      check($sformatf("v%0d_sclk_rises", i), 32'(rises), 32'(DW));
      check($sformatf("v%0d_csn_low", i),  32'(csn),   32'(EXP_CSN));
      check($sformatf("v%0d_mosi_order", i), 32'(mw),  32'(vecs[i].tx));
      check($sformatf("v%0d_mosi_active", i), 32'(mh != 0), 32'(vecs[i].tx != 0));
    end

    // tx_valid held high across two words
    mode = 2'd0;
    acc0 = acc_cnt;
    @(posedge clk); #1;
    tx_data = 8'h12; tx_valid = 1'b1;
    wait_rv(200, ok);
    check("hold_rx_first", 32'(rx_data), 32'h12);
    check("hold_ready_in_done", 32'(tx_ready), 32'd0);
    rv0 = cyc;
    tx_data = 8'h34;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk); #1;
    check("hold_second_accept", 32'(acc_cyc), 32'(rv0 + 1));
    check("hold_csn_gap", 32'(csn_fall_cyc - csn_rise_cyc), 32'd2);
    wait_rv(200, ok);
    check("hold_rx_second", 32'(rx_data), 32'h34);
    @(negedge clk); #1;
    check("hold_accept_count", 32'(acc_cnt - acc0), 32'd2);

    // Reset after the third sclk rise aborts the transfer
    rv0 = rv_cnt;
    @(posedge clk); #1;
    tx_data = 8'hC3; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    nr = 0; prev_s = 0;
    for (int n = 0; n < 200 && nr < 3; n++) begin
      @(posedge clk); #1;
      if (sclk && prev_s == 0) nr++;
      prev_s = int'(sclk);
    end
    check("abort_reached_3_rises", 32'(nr), 32'd3);
    rst = 1'b1; #1;
    check("abort_cs_n",     32'(cs_n),     32'd1);
    check("abort_sclk",     32'(sclk),     32'd0);
    check("abort_busy",     32'(busy),     32'd0);
    check("abort_tx_ready", 32'(tx_ready), 32'd1);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (60) @(posedge clk); #1;
    check("abort_no_rx_valid", 32'(rv_cnt - rv0), 32'd0);
    check("abort_rx_data",     32'(rx_data),      32'd0);
    send(8'h5A, rx, lat, rises, csn, mw, mh);
    check("post_abort_rx",      32'(rx),    32'h5A);
    check("post_abort_latency", 32'(lat),   32'(EXP_LAT));
    check("post_abort_rises",   32'(rises), 32'(DW));

    // Inputs changed while busy are ignored
    acc0 = acc_cnt;
    @(posedge clk); #1;
    tx_data = 8'h96; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (10) @(posedge clk); #1;
    tx_data = 8'h11; tx_valid = 1'b1;
    check("busy_ready_low", 32'(tx_ready), 32'd0);
    check("busy_busy_high", 32'(busy),     32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_rv(200, ok);
    check("busy_rx_original", 32'(rx_data), 32'h96);
    repeat (5) @(posedge clk); #1;
    check("busy_no_extra_accept", 32'(acc_cnt - acc0), 32'd1);
    check("busy_idle_after", 32'(busy), 32'd0);

    // 32-bit instance, CLK_DIV=4
    @(posedge clk); #1;
    t32 = cyc;
    tx_data32 = 32'hDEADBEEF; tx_valid32 = 1'b1;
    @(posedge clk); #1;
    tx_valid32 = 1'b0;
    tx_data32 = 32'h0;
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      if (rx_valid32) begin ok = 1'b1; break; end
    end
    check("dw32_rx_valid_seen", 32'(ok), 32'd1);
    check("dw32_rx_data", rx_data32, 32'hDEADBEEF);
    check("dw32_latency", 32'(cyc - t32), 32'd265);
    check("dw32_cs_n_done", 32'(cs_n32), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
